// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared types for the Zhinx FPU issue controller: instruction layout, op codes,
// rounding modes, execution classes and the decode result.
package fpu_issue_ctrl_pkg;

  localparam logic [6:0] OPCODE_OPFP   = 7'b1010011;
  localparam logic [6:0] OPCODE_FMADD  = 7'b1000011;
  localparam logic [6:0] OPCODE_FMSUB  = 7'b1000111;
  localparam logic [6:0] OPCODE_FNMSUB = 7'b1001011;
  localparam logic [6:0] OPCODE_FNMADD = 7'b1001111;

  localparam logic [1:0] FMT_HALF = 2'b10;

  localparam logic [4:0] F5_FADD    = 5'b00000;
  localparam logic [4:0] F5_FSUB    = 5'b00001;
  localparam logic [4:0] F5_FMUL    = 5'b00010;
  localparam logic [4:0] F5_FDIV    = 5'b00011;
  localparam logic [4:0] F5_FSGNJ   = 5'b00100;
  localparam logic [4:0] F5_FMINMAX = 5'b00101;
  localparam logic [4:0] F5_FSQRT   = 5'b01011;
  localparam logic [4:0] F5_FCOMP   = 5'b10100;
  localparam logic [4:0] F5_FCLASS  = 5'b11100;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000, RM_RTZ = 3'b001, RM_RDN = 3'b010,
    RM_RUP = 3'b011, RM_RMM = 3'b100, RM_DYN = 3'b111
  } fpu_rm_t;

  typedef enum logic [2:0] {
    RM_FLE = 3'b000, RM_FLT = 3'b001, RM_FEQ = 3'b010
  } fpu_cmp_rm_t;

  typedef enum logic [3:0] {
    FPU_HALF_ADD, FPU_HALF_SUB, FPU_HALF_MUL, FPU_HALF_DIV, FPU_HALF_SQRT,
    FPU_HALF_MADD, FPU_HALF_MSUB, FPU_HALF_NMADD, FPU_HALF_NMSUB,
    FPU_HALF_SGNJ, FPU_HALF_MINMAX, FPU_HALF_CMP, FPU_HALF_CLASS
  } fpu_operation_t;

  // R4-type ops reuse the funct5 slot as rs3.
  typedef struct packed {
    logic [4:0] funct5;
    logic [1:0] fmt;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] rm;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rv32zhinx_insn_t;

  typedef enum logic [1:0] {EXEC_COMB, EXEC_PIPE, EXEC_DIV, EXEC_ILLEGAL} fpu_exec_class_t;
  typedef enum logic [1:0] {WB_COMB = 2'd0, WB_PIPE = 2'd1, WB_DIV = 2'd2} fpu_wb_src_t;

  typedef struct packed {
    fpu_exec_class_t cls;
    fpu_operation_t  op;
    logic [2:0]      rm;
  } fpu_decode_t;

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Issue/execute/writeback bundle between the core side (master) and the controller (slave).
interface fpu_issue_ctrl_if;
  import fpu_issue_ctrl_pkg::*;

  logic            insn_valid;
  rv32zhinx_insn_t insn;
  logic            insn_ready;
  logic [2:0]      frm;
  fpu_operation_t  exec_op;
  logic [2:0]      exec_rm;
  logic            comb_start;
  logic            pipe_start;
  logic            div_start;
  logic            div_done;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  fpu_wb_src_t     wb_src;
  logic            illegal;
  logic            busy;

  modport master (
    output insn_valid, insn, frm, div_done,
    input  insn_ready, exec_op, exec_rm, comb_start, pipe_start, div_start,
           wb_valid, wb_rd, wb_src, illegal, busy
  );

  modport slave (
    input  insn_valid, insn, frm, div_done,
    output insn_ready, exec_op, exec_rm, comb_start, pipe_start, div_start,
           wb_valid, wb_rd, wb_src, illegal, busy
  );
endinterface

// File: rtl/fpu_zhinx_decode.sv
// Combinational Zhinx decode: instruction word + dynamic frm -> class, op, resolved rm.
module fpu_zhinx_decode
  import fpu_issue_ctrl_pkg::*;
(
  input  rv32zhinx_insn_t insn_i,
  input  logic [2:0]      frm_i,
  output fpu_decode_t     dec_o
);
  logic       arith;
  logic [2:0] rm_res;
  logic       unused_rs1;

  assign unused_rs1 = ^insn_i.rs1;
  assign rm_res     = (insn_i.rm == RM_DYN) ? frm_i : insn_i.rm;

  always_comb begin
    dec_o.cls = EXEC_ILLEGAL;
    dec_o.op  = FPU_HALF_ADD;
    dec_o.rm  = insn_i.rm;
    arith     = 1'b0;
    case (insn_i.opcode)
      OPCODE_OPFP: begin
        case (insn_i.funct5)
          F5_FADD: begin dec_o.cls = EXEC_PIPE; dec_o.op = FPU_HALF_ADD; arith = 1'b1; end
          F5_FSUB: begin dec_o.cls = EXEC_PIPE; dec_o.op = FPU_HALF_SUB; arith = 1'b1; end
          F5_FMUL: begin dec_o.cls = EXEC_PIPE; dec_o.op = FPU_HALF_MUL; arith = 1'b1; end
          F5_FDIV: begin dec_o.cls = EXEC_DIV;  dec_o.op = FPU_HALF_DIV; arith = 1'b1; end
          F5_FSQRT: if (insn_i.rs2 == 5'd0) begin
            dec_o.cls = EXEC_DIV; dec_o.op = FPU_HALF_SQRT; arith = 1'b1;
          end
          F5_FMINMAX: if (insn_i.rm inside {3'b000, 3'b001}) begin
            dec_o.cls = EXEC_COMB; dec_o.op = FPU_HALF_MINMAX;
          end
          F5_FSGNJ: if (insn_i.rm inside {3'b000, 3'b001, 3'b010}) begin
            dec_o.cls = EXEC_COMB; dec_o.op = FPU_HALF_SGNJ;
          end
          F5_FCOMP: if (insn_i.rm inside {RM_FLE, RM_FLT, RM_FEQ}) begin
            dec_o.cls = EXEC_COMB; dec_o.op = FPU_HALF_CMP;
          end
          F5_FCLASS: if (insn_i.rs2 == 5'd0 && insn_i.rm == 3'b001) begin
            dec_o.cls = EXEC_COMB; dec_o.op = FPU_HALF_CLASS;
          end
          default: ;
        endcase
      end
      OPCODE_FMADD:  begin dec_o.cls = EXEC_PIPE; dec_o.op = FPU_HALF_MADD;  arith = 1'b1; end
      OPCODE_FMSUB:  begin dec_o.cls = EXEC_PIPE; dec_o.op = FPU_HALF_MSUB;  arith = 1'b1; end
      OPCODE_FNMADD: begin dec_o.cls = EXEC_PIPE; dec_o.op = FPU_HALF_NMADD; arith = 1'b1; end
      OPCODE_FNMSUB: begin dec_o.cls = EXEC_PIPE; dec_o.op = FPU_HALF_NMSUB; arith = 1'b1; end
      default: ;
    endcase
    // rm_res >= 101 covers reserved static modes and DYN with a reserved frm alike.
    if (arith) begin
      dec_o.rm = rm_res;
      if (rm_res >= 3'b101) dec_o.cls = EXEC_ILLEGAL;
    end
    if (insn_i.fmt != FMT_HALF) dec_o.cls = EXEC_ILLEGAL;
  end
endmodule

// File: rtl/fpu_issue_ctrl.sv
// Zhinx FPU issue controller: starts comb/pipe/div units and keeps writebacks in
// program order on a single port using a pipe tag shift register and a div FSM.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_LAT = 3
) (
  input logic            CLK,
  input logic            RST,
  fpu_issue_ctrl_if.slave io
);
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] DIV_WAIT = 1'b1;

  fpu_decode_t dec;
  logic [0:0]  state_q, state_d;
  logic [PIPE_LAT-1:0]       vld_pipe_q;
  logic [PIPE_LAT-1:0][4:0]  rd_pipe_q;
  logic        ready, accept, div_ack;
  logic        comb_q, pipe_q, div_q, illegal_q, wb_q;
  logic [4:0]  wb_rd_q, div_rd_q;
  fpu_wb_src_t wb_src_q;
  fpu_operation_t exec_op_q;
  logic [2:0]  exec_rm_q;

  fpu_zhinx_decode u_dec (.insn_i(io.insn), .frm_i(io.frm), .dec_o(dec));

  // Every live pipe tag writes back after this cycle, so non-pipe ops wait for empty.
  always_comb begin
    ready = 1'b0;
    if (!RST && state_q == IDLE) ready = (dec.cls == EXEC_PIPE) ? 1'b1 : ~|vld_pipe_q;
  end

  assign accept  = io.insn_valid & ready;
  assign div_ack = (state_q == DIV_WAIT) & io.div_done & ~RST;

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && accept && dec.cls == EXEC_DIV) state_d = DIV_WAIT;
    else if (div_ack)                                      state_d = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      vld_pipe_q <= '0;
      rd_pipe_q  <= '0;
      comb_q     <= 1'b0;
      pipe_q     <= 1'b0;
      div_q      <= 1'b0;
      illegal_q  <= 1'b0;
      wb_q       <= 1'b0;
      wb_rd_q    <= '0;
      wb_src_q   <= WB_COMB;
      div_rd_q   <= '0;
      exec_op_q  <= FPU_HALF_ADD;
      exec_rm_q  <= '0;
    end else begin
      state_q       <= state_d;
      vld_pipe_q[0] <= accept && dec.cls == EXEC_PIPE;
      rd_pipe_q[0]  <= io.insn.rd;
      for (int k = 1; k < int'(PIPE_LAT); k++) begin
        vld_pipe_q[k] <= vld_pipe_q[k-1];
        rd_pipe_q[k]  <= rd_pipe_q[k-1];
      end
      comb_q    <= accept && dec.cls == EXEC_COMB;
      pipe_q    <= accept && dec.cls == EXEC_PIPE;
      div_q     <= accept && dec.cls == EXEC_DIV;
      illegal_q <= accept && dec.cls == EXEC_ILLEGAL;
      if (accept && dec.cls != EXEC_ILLEGAL) begin
        exec_op_q <= dec.op;
        exec_rm_q <= dec.rm;
      end
      if (accept && dec.cls == EXEC_DIV) div_rd_q <= io.insn.rd;
      // Comb issue needs an empty pipe, so it never meets a retiring pipe tag.
      wb_q <= (accept && dec.cls == EXEC_COMB) | vld_pipe_q[PIPE_LAT-1];
      if (vld_pipe_q[PIPE_LAT-1]) begin
        wb_rd_q  <= rd_pipe_q[PIPE_LAT-1];
        wb_src_q <= WB_PIPE;
      end else if (accept && dec.cls == EXEC_COMB) begin
        wb_rd_q  <= io.insn.rd;
        wb_src_q <= WB_COMB;
      end
    end
  end

  assign io.insn_ready = ready;
  assign io.exec_op    = exec_op_q;
  assign io.exec_rm    = exec_rm_q;
  assign io.comb_start = comb_q;
  assign io.pipe_start = pipe_q;
  assign io.div_start  = div_q;
  assign io.illegal    = illegal_q;
  assign io.wb_valid   = wb_q | div_ack;
  assign io.wb_rd      = div_ack ? div_rd_q : wb_rd_q;
  assign io.wb_src     = div_ack ? WB_DIV : wb_src_q;
  assign io.busy       = (state_q != IDLE) | (|vld_pipe_q) | comb_q | pipe_q | div_q;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomized + directed bench for fpu_issue_ctrl against a cycle-scheduled scoreboard model.
module tb_fpu_issue_ctrl;
  import fpu_issue_ctrl_pkg::*;

  localparam int L = 3;
  localparam int C_NONE = 0, C_COMB = 1, C_PIPE = 2, C_DIV = 3, C_ILL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_issue_ctrl_if bus();
  fpu_issue_ctrl #(.PIPE_LAT(L)) dut (.CLK(clk), .RST(rst), .io(bus));

  int n_cmp = 0, n_bad = 0, cyc = 0;

  // Model: expected events keyed by the cycle they must appear in.
  bit div_pend;
  int div_rd;
  int done_at = -1;
  int pipe_wb[$];
  int wb_rd_at[int], wb_src_at[int], st_at[int], op_at[int], rm_at[int];
  int force_lat = 0;
  bit spur_req, rnd_mode, post_rst;
  logic [34:0] dir_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] f5, input logic [1:0] fmt,
                                      input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] rm, input logic [4:0] rd,
                                      input logic [6:0] opc);
    return {f5, fmt, rs2, rs1, rm, rd, opc};
  endfunction

  task automatic push(input logic [31:0] w, input logic [2:0] f = 3'b000);
    dir_q.push_back({f, w});
  endtask

  // Reference decode written from the instruction rules.
  task automatic ref_dec(input logic [31:0] w, input logic [2:0] f,
                         output int cls, output int op, output logic [2:0] rm);
    logic [6:0] opc;
    logic [4:0] f5, rs2;
    logic [1:0] fmt;
    bit arith;
    opc = w[6:0]; f5 = w[31:27]; fmt = w[26:25]; rs2 = w[24:20]; rm = w[14:12];
    cls = C_ILL; op = int'(FPU_HALF_ADD); arith = 0;
    if (opc == OPCODE_OPFP) begin
      if (f5 == F5_FADD) begin cls = C_PIPE; op = int'(FPU_HALF_ADD); arith = 1; end
      if (f5 == F5_FSUB) begin cls = C_PIPE; op = int'(FPU_HALF_SUB); arith = 1; end
      if (f5 == F5_FMUL) begin cls = C_PIPE; op = int'(FPU_HALF_MUL); arith = 1; end
      if (f5 == F5_FDIV) begin cls = C_DIV;  op = int'(FPU_HALF_DIV); arith = 1; end
      if (f5 == F5_FSQRT && rs2 == 0) begin cls = C_DIV; op = int'(FPU_HALF_SQRT); arith = 1; end
      if (f5 == F5_FMINMAX && rm <= 3'd1) begin cls = C_COMB; op = int'(FPU_HALF_MINMAX); end
      if (f5 == F5_FSGNJ && rm <= 3'd2) begin cls = C_COMB; op = int'(FPU_HALF_SGNJ); end
      if (f5 == F5_FCOMP && rm <= 3'd2) begin cls = C_COMB; op = int'(FPU_HALF_CMP); end
      if (f5 == F5_FCLASS && rs2 == 0 && rm == 3'd1) begin cls = C_COMB; op = int'(FPU_HALF_CLASS); end
    end else if (opc == OPCODE_FMADD)  begin cls = C_PIPE; op = int'(FPU_HALF_MADD);  arith = 1; end
    else if (opc == OPCODE_FMSUB)      begin cls = C_PIPE; op = int'(FPU_HALF_MSUB);  arith = 1; end
    else if (opc == OPCODE_FNMADD)     begin cls = C_PIPE; op = int'(FPU_HALF_NMADD); arith = 1; end
    else if (opc == OPCODE_FNMSUB)     begin cls = C_PIPE; op = int'(FPU_HALF_NMSUB); arith = 1; end
    if (arith) begin
      if (rm == 3'd5 || rm == 3'd6) cls = C_ILL;
      if (rm == 3'd7) begin
        if (f >= 3'd5) cls = C_ILL;
        else rm = f;
      end
    end
    if (fmt != FMT_HALF) cls = C_ILL;
  endtask

  function automatic logic [31:0] gen_insn();
    logic [6:0] opc;
    logic [4:0] f5, rs2;
    logic [1:0] fmt;
    logic [2:0] rm;
    opc = OPCODE_OPFP;
    case ($urandom_range(0, 11))
      0: f5 = F5_FADD;
      1: f5 = F5_FSUB;
      2: f5 = F5_FMUL;
      3: f5 = F5_FDIV;
      4: f5 = F5_FSQRT;
      5: f5 = F5_FSGNJ;
      6: f5 = F5_FMINMAX;
      7: f5 = F5_FCOMP;
      8: f5 = F5_FCLASS;
      9: begin
        f5 = 5'($urandom);
        case ($urandom_range(0, 3))
          0: opc = OPCODE_FMADD;
          1: opc = OPCODE_FMSUB;
          2: opc = OPCODE_FNMADD;
          default: opc = OPCODE_FNMSUB;
        endcase
      end
      10: f5 = 5'($urandom);
      default: begin f5 = 5'($urandom); opc = 7'($urandom); end
    endcase
    fmt = ($urandom_range(0, 9) == 0) ? 2'($urandom) : FMT_HALF;
    rs2 = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
    rm  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
    return enc(f5, fmt, rs2, 5'($urandom), rm, 5'($urandom), opc);
  endfunction

  task automatic tick();
    logic [31:0] w;
    logic [2:0] f, rm;
    logic v, dd, from_dir, e_ready, e_wb;
    int cls, op, e_rd, e_src, e_st;
    from_dir = 0;
    if (dir_q.size() != 0) begin
      {f, w} = dir_q[0]; v = 1; from_dir = 1;
    end else if (rnd_mode) begin
      v = ($urandom_range(0, 9) < 7); w = gen_insn(); f = 3'($urandom_range(0, 7));
    end else begin
      v = 0; w = 32'h0; f = 3'h0;
    end
    dd = (cyc == done_at) || (!div_pend && (spur_req || (rnd_mode && $urandom_range(0, 15) == 0)));
    spur_req = 0;
    bus.insn_valid = v; bus.insn = w; bus.frm = f; bus.div_done = dd;
    @(negedge clk);
    if (rst) begin
      chk("ready_in_rst", 32'(bus.insn_ready), 0);
      div_pend = 0; done_at = -1; pipe_wb.delete();
      wb_rd_at.delete(); wb_src_at.delete(); st_at.delete(); op_at.delete(); rm_at.delete();
      post_rst = 1;
    end else begin
      ref_dec(w, f, cls, op, rm);
      while (pipe_wb.size() != 0 && pipe_wb[0] <= cyc) void'(pipe_wb.pop_front());
      e_ready = !div_pend && (cls == C_PIPE || pipe_wb.size() == 0);
      chk("insn_ready", 32'(bus.insn_ready), 32'(e_ready));
      e_wb = 0; e_rd = 0; e_src = 0;
      if (div_pend && dd) begin e_wb = 1; e_rd = div_rd; e_src = 2; end
      else if (wb_rd_at.exists(cyc)) begin e_wb = 1; e_rd = wb_rd_at[cyc]; e_src = wb_src_at[cyc]; end
      if (wb_rd_at.exists(cyc)) begin wb_rd_at.delete(cyc); wb_src_at.delete(cyc); end
      chk("wb_valid", 32'(bus.wb_valid), 32'(e_wb));
      if (e_wb) begin
        chk("wb_rd", 32'(bus.wb_rd), 32'(e_rd));
        chk("wb_src", 32'(bus.wb_src), 32'(e_src));
      end
      e_st = st_at.exists(cyc) ? st_at[cyc] : C_NONE;
      chk("comb_start", 32'(bus.comb_start), 32'(e_st == C_COMB));
      chk("pipe_start", 32'(bus.pipe_start), 32'(e_st == C_PIPE));
      chk("div_start", 32'(bus.div_start), 32'(e_st == C_DIV));
      chk("illegal", 32'(bus.illegal), 32'(e_st == C_ILL));
      if (e_st inside {C_COMB, C_PIPE, C_DIV}) begin
        chk("exec_op", 32'(bus.exec_op), 32'(op_at[cyc]));
        chk("exec_rm", 32'(bus.exec_rm), 32'(rm_at[cyc]));
      end
      if (st_at.exists(cyc)) begin st_at.delete(cyc); op_at.delete(cyc); rm_at.delete(cyc); end
      chk("busy", 32'(bus.busy),
          32'(div_pend || pipe_wb.size() != 0 || e_st inside {C_COMB, C_PIPE, C_DIV}));
      if (post_rst) begin
        chk("rst_exec_op", 32'(bus.exec_op), 32'(FPU_HALF_ADD));
        chk("rst_exec_rm", 32'(bus.exec_rm), 0);
        post_rst = 0;
      end
      if (div_pend && dd) begin div_pend = 0; done_at = -1; end
      if (v && e_ready) begin
        st_at[cyc+1] = cls; op_at[cyc+1] = op; rm_at[cyc+1] = int'(rm);
        if (cls == C_COMB) begin wb_rd_at[cyc+1] = int'(w[11:7]); wb_src_at[cyc+1] = 0; end
        if (cls == C_PIPE) begin
          wb_rd_at[cyc+1+L] = int'(w[11:7]); wb_src_at[cyc+1+L] = 1;
          pipe_wb.push_back(cyc + 1 + L);
        end
        if (cls == C_DIV) begin
          div_pend = 1; div_rd = int'(w[11:7]);
          done_at = cyc + 1 + ((force_lat != 0) ? force_lat : int'($urandom_range(1, 12)));
        end
        if (from_dir) void'(dir_q.pop_front());
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run_idle(input int max);
    int n;
    n = 0;
    while ((dir_q.size() != 0 || div_pend || wb_rd_at.num() != 0 || st_at.num() != 0) && n < max) begin
      tick(); n++;
    end
    if (n >= max) chk("drain_timeout", 32'(n), 32'(max - 1));
  endtask

  task automatic wait_accept(input int max);
    int n;
    n = 0;
    while (dir_q.size() != 0 && n < max) begin tick(); n++; end
    if (n >= max) chk("accept_timeout", 32'(n), 32'(max - 1));
  endtask

  initial begin
    rst = 1'b1;
    bus.insn_valid = 0; bus.insn = '0; bus.frm = '0; bus.div_done = 0;
    repeat (2) tick();
    rst = 1'b0;

    push(enc(F5_FADD, FMT_HALF, 5'd2, 5'd1, 3'b000, 5'd5, OPCODE_OPFP));
    run_idle(30);

    for (int i = 1; i <= 3; i++) push(enc(F5_FMUL, FMT_HALF, 5'd4, 5'd3, 3'b000, 5'(i), OPCODE_OPFP));
    push(enc(F5_FCOMP, FMT_HALF, 5'd2, 5'd1, 3'b010, 5'd9, OPCODE_OPFP));
    run_idle(40);

    force_lat = 10;
    push(enc(F5_FDIV, FMT_HALF, 5'd2, 5'd1, 3'b000, 5'd7, OPCODE_OPFP));
    run_idle(40);
    force_lat = 0;
    spur_req = 1;
    repeat (2) tick();

    push(enc(F5_FADD, 2'b00, 5'd2, 5'd1, 3'b000, 5'd4, OPCODE_OPFP));
    push(enc(F5_FMINMAX, FMT_HALF, 5'd2, 5'd1, 3'b011, 5'd4, OPCODE_OPFP));
    push(enc(F5_FSQRT, FMT_HALF, 5'd3, 5'd1, 3'b000, 5'd4, OPCODE_OPFP));
    push(enc(F5_FADD, FMT_HALF, 5'd2, 5'd1, 3'b111, 5'd4, OPCODE_OPFP), 3'b111);
    push(enc(F5_FSUB, FMT_HALF, 5'd2, 5'd1, 3'b111, 5'd6, OPCODE_OPFP), 3'b010);
    push(enc(F5_FCLASS, FMT_HALF, 5'd0, 5'd1, 3'b001, 5'd8, OPCODE_OPFP));
    run_idle(40);

    push(enc(F5_FDIV, FMT_HALF, 5'd2, 5'd1, 3'b000, 5'd12, OPCODE_OPFP));
    force_lat = 10;
    wait_accept(20);
    repeat (2) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    force_lat = 0;
    push(enc(F5_FADD, FMT_HALF, 5'd2, 5'd1, 3'b000, 5'd13, OPCODE_OPFP));
    run_idle(30);

    push(enc(F5_FADD, FMT_HALF, 5'd2, 5'd1, 3'b000, 5'd10, OPCODE_OPFP));
    push(enc(F5_FADD, FMT_HALF, 5'd2, 5'd1, 3'b000, 5'd11, OPCODE_OPFP));
    wait_accept(20);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    spur_req = 1;
    push(enc(F5_FADD, FMT_HALF, 5'd2, 5'd1, 3'b000, 5'd14, OPCODE_OPFP));
    run_idle(30);

    rnd_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    rnd_mode = 0;
    run_idle(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Issue controller for the half-precision (Zhinx) FPU. It accepts one RV32 Zhinx instruction word per handshake and decodes it to an `fpu_operation_t` and a rounding mode. It dispatches each op to one of three execution classes: single-cycle, fixed-latency pipelined, or iterative div/sqrt. It sequences their starts and tracks destination tags so that writebacks occur in program order on one writeback port.

## Interface
Parameters:
- `PIPE_LAT`, 3: latency in cycles of the pipelined unit (add/sub/mul/fused ops); legal range 1–7.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `insn_valid`  in  1  instruction word valid.
- `insn`  in  32  `rv32zhinx_insn_t`.
- `insn_ready`  out  1  controller accepts `insn` this cycle.
- `frm`  in  3  dynamic rounding mode, used when `insn.rm == RM_DYN`.
- `exec_op`  out  `fpu_operation_t`  decoded op for the started unit.
- `exec_rm`  out  3  resolved rm (RM_DYN replaced by `frm`), or the funct sub-select for minmax/sgnj/cmp.
- `comb_start`  out  1  pulse; single-cycle unit evaluates `exec_*` this cycle.
- `pipe_start`  out  1  pulse; pipelined unit captures `exec_*`.
- `div_start`  out  1  pulse; iterative unit begins.
- `div_done`  in  1  iterative unit result valid (one-cycle pulse).
- `wb_valid`  out  1  result writeback this cycle.
- `wb_rd`  out  5  writeback destination.
- `wb_src`  out  2  0 = comb, 1 = pipe, 2 = div; selects the result mux.
- `illegal`  out  1  pulse; the accepted instruction was illegal.
- `busy`  out  1  any op in flight.

## Operation
- Decode, combinational on `insn`:
  - `OPCODE_OPFP`: funct5 selects the op.
    - FADD/FSUB/FMUL go to pipe.
    - FDIV goes to div.
    - FSQRT goes to div and requires `rs2 == 0`.
    - FMINMAX requires rm ∈ {000 MIN, 001 MAX} and goes to comb.
    - FSGNJ requires rm ∈ {000, 001, 010} and goes to comb.
    - FCOMP requires rm ∈ {RM_FEQ, RM_FLT, RM_FLE} and goes to comb.
    - FCLASS requires rs2 = 0 and rm = 001, and goes to comb.
  - `OPCODE_FMADD/FMSUB/FNMADD/FNMSUB`: go to pipe as MADD/MSUB/NMADD/NMSUB.
  - Anything else is illegal, as is:
    - `fmt != FMT_HALF`;
    - rm ∈ {101, 110} for arithmetic ops;
    - RM_DYN with `frm` ∈ {101, 110, 111}.
- Tag tracking: a `PIPE_LAT`-deep valid/rd shift register for pipe ops.
- State machine (`IDLE`, `DIV_WAIT`):
  - IDLE → DIV_WAIT on acceptance of a div-class op.
  - DIV_WAIT → IDLE in the cycle `div_done` is seen.
- `insn_ready` (combinational from the decoded class):
  - Pipe class: `state == IDLE`.
  - Comb, div or illegal: `state == IDLE` and the shift register is empty in all stages that write back after the current cycle. This prevents writeback collision and reordering.
- Illegal instructions are accepted. `illegal` pulses in cycle T+1; there is no start and no writeback.
- `busy` = (state != IDLE) | any shift-register stage valid | any start pulse this cycle.

## Timing
- Acceptance cycle T: `insn_valid & insn_ready`.
- `exec_op`, `exec_rm`, start pulse, `illegal` are all registered and appear in T+1.
- Comb: `wb_valid` in T+1, `wb_src = 0`.
- Pipe: `wb_valid` in T+1+`PIPE_LAT`, `wb_src = 1`.
  - Back-to-back pipe ops yield back-to-back writebacks in order.
- Div: `wb_valid` in the cycle `div_done` is seen (≥ T+2), `wb_src = 2`.
  - `insn_ready` can rise in the following cycle.
- A `div_done` received outside DIV_WAIT is ignored.
- The rd of the div op is held in a register until `div_done`.
- `wb_valid` is never asserted twice in one cycle, by construction.
- Reset values:
  - All outputs 0; `exec_op = FPU_HALF_ADD`.
  - State IDLE; shift register cleared.
- `RST` mid-operation drops every in-flight tag. No writeback is produced for them. `insn_ready` is 0 during the `RST` cycle.

## Structure
- The `fpu_types_pkg` additions:
  - `fpu_exec_class_t` enum {COMB, PIPE, DIV, ILLEGAL};
  - `fpu_wb_src_t`;
  - decode struct {class, op, rm};
  - reuse of `rv32zhinx_insn_t`, `fpu_rm_t`, `fpu_cmp_rm_t`.
- Sub-module `fpu_zhinx_decode`: purely combinational `insn`/`frm` → decode struct. It is reusable by the verification model.
- The top holds the FSM, the tag shift register and the output registers.

## Test plan
- FADD with rs1=1, rs2=2, rd=5, fmt=10, rm=000, `PIPE_LAT=3`, accepted at T → `pipe_start` at T+1 with `exec_op = FPU_HALF_ADD`; `wb_valid` with `wb_rd = 5`, `wb_src = 1` at T+4.
- Three FMULs back-to-back (rd 1, 2, 3), then FEQ (rm=010) → FEQ `insn_ready` stays low until the last FMUL writes back. Writebacks follow in the order rd 1, 2, 3, then the FEQ rd. They occur in consecutive or later cycles with no overlap.
- FDIV rd=7, `div_done` driven 10 cycles after `div_start` → `insn_ready = 0` throughout. `wb_valid`, `wb_rd = 7` in the `div_done` cycle; ready returns the next cycle. A spurious `div_done` in IDLE produces no writeback.
- Illegal cases: fmt=00; FMINMAX rm=011; FSQRT with rs2=3; RM_DYN with `frm = 111` → each accepted, `illegal` pulses 1 cycle, no start, no writeback.
- RM_DYN with `frm = 010` on FSUB → `exec_rm = 010`. FCLASS (rm=001, rs2=0) → comb writeback at T+1, `exec_op = FPU_HALF_CLASS`.
- Reset asserted 2 cycles into FDIV, and separately with 2 pipe ops in flight → outputs return to reset values the next cycle. No stale writeback and no `illegal` afterwards. A new FADD issues normally.
